// File: rtl/dpram_req_arbiter.sv
// Request-side front end for a dual-port RAM: one registered request slot per port,
// same-address write collisions serialized with alternating priority.
// Optional collision counter enabled by defining DPRAM_ARB_STATS_EN.
module dpram_req_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  // upstream port A
  input  logic              in_valid_a,
  output logic              in_ready_a,
  input  logic              in_we_a,
  input  logic [ADDR_W-1:0] in_addr_a,
  input  logic [DATA_W-1:0] in_data_a,
  // upstream port B
  input  logic              in_valid_b,
  output logic              in_ready_b,
  input  logic              in_we_b,
  input  logic [ADDR_W-1:0] in_addr_b,
  input  logic [DATA_W-1:0] in_data_b,
  // RAM port A
  output logic              valid_a,
  input  logic              ready_a,
  output logic              we_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] data_a,
  // RAM port B
  output logic              valid_b,
  input  logic              ready_b,
  output logic              we_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_b,
  // statistics
  output logic [15:0]       conflict_cnt
);

  logic              r_slot_vld_a;
  logic              r_we_a;
  logic [ADDR_W-1:0] r_addr_a;
  logic [DATA_W-1:0] r_data_a;
  logic              r_slot_vld_b;
  logic              r_we_b;
  logic [ADDR_W-1:0] r_addr_b;
  logic [DATA_W-1:0] r_data_b;
  logic              r_prio;
  logic              r_stall_a;
  logic              r_stall_b;

  logic              w_hazard;
  logic              w_a_wins;
  logic              w_valid_a;
  logic              w_valid_b;
  logic              w_fire_a;
  logic              w_fire_b;
  logic              w_load_a;
  logic              w_load_b;
  logic              w_resolved;

  assign w_hazard = r_slot_vld_a & r_slot_vld_b & (r_addr_a == r_addr_b) & (r_we_a | r_we_b);

  // Winner selection. A port already presenting a stalled request keeps the grant so
  // its outputs never retract mid-handshake; otherwise the alternating priority decides.
  always_comb begin
    w_a_wins = 1'b1;
    if (r_stall_a) begin
      w_a_wins = 1'b1;
    end else if (r_stall_b) begin
      w_a_wins = 1'b0;
    end else begin
      w_a_wins = ~r_prio;
    end
  end

  // RAM-side valids: the hazard loser is masked until the winner has transferred.
  always_comb begin
    w_valid_a = r_slot_vld_a;
    w_valid_b = r_slot_vld_b;
    if (w_hazard) begin
      if (w_a_wins) begin
        w_valid_b = 1'b0;
      end else begin
        w_valid_a = 1'b0;
      end
    end else begin
      w_valid_a = r_slot_vld_a;
      w_valid_b = r_slot_vld_b;
    end
  end

  assign w_fire_a   = w_valid_a & ready_a;
  assign w_fire_b   = w_valid_b & ready_b;
  assign in_ready_a = ~r_slot_vld_a | w_fire_a;
  assign in_ready_b = ~r_slot_vld_b | w_fire_b;
  assign w_load_a   = in_valid_a & in_ready_a;
  assign w_load_b   = in_valid_b & in_ready_b;
  assign w_resolved = w_hazard & (w_a_wins ? w_fire_a : w_fire_b);

  // Port A request slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_vld_a <= 1'b0;
      r_we_a       <= 1'b0;
      r_addr_a     <= {ADDR_W{1'b0}};
      r_data_a     <= {DATA_W{1'b0}};
    end else if (w_load_a) begin
      r_slot_vld_a <= 1'b1;
      r_we_a       <= in_we_a;
      r_addr_a     <= in_addr_a;
      r_data_a     <= in_data_a;
    end else if (w_fire_a) begin
      r_slot_vld_a <= 1'b0;
    end else begin
      r_slot_vld_a <= r_slot_vld_a;
    end
  end

  // Port B request slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_vld_b <= 1'b0;
      r_we_b       <= 1'b0;
      r_addr_b     <= {ADDR_W{1'b0}};
      r_data_b     <= {DATA_W{1'b0}};
    end else if (w_load_b) begin
      r_slot_vld_b <= 1'b1;
      r_we_b       <= in_we_b;
      r_addr_b     <= in_addr_b;
      r_data_b     <= in_data_b;
    end else if (w_fire_b) begin
      r_slot_vld_b <= 1'b0;
    end else begin
      r_slot_vld_b <= r_slot_vld_b;
    end
  end

  // Priority flips to the other port whenever a hazard winner transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (w_resolved) begin
      r_prio <= w_a_wins;
    end else begin
      r_prio <= r_prio;
    end
  end

  // Remember which ports are presenting a request the RAM has not yet taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_a <= 1'b0;
      r_stall_b <= 1'b0;
    end else begin
      r_stall_a <= w_valid_a & ~ready_a;
      r_stall_b <= w_valid_b & ~ready_b;
    end
  end

`ifdef DPRAM_ARB_STATS_EN
  logic [15:0] r_conflict_cnt;

  // Saturating count of resolved collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= 16'h0000;
    end else if (w_resolved && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'h0001;
    end else begin
      r_conflict_cnt <= r_conflict_cnt;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  assign conflict_cnt = 16'h0000;
`endif

  assign valid_a = w_valid_a;
  assign we_a    = r_we_a;
  assign addr_a  = r_addr_a;
  assign data_a  = r_data_a;
  assign valid_b = w_valid_b;
  assign we_b    = r_we_b;
  assign addr_b  = r_addr_b;
  assign data_b  = r_data_b;

endmodule

// File: tb/tb_dpram_req_arbiter.sv
// Directed self-checking bench for dpram_req_arbiter with a behavioural RAM model
// that commits writes on each RAM-side handshake.
module tb_dpram_req_arbiter;

  localparam int DW = 8;
  localparam int AW = 6;
`ifdef DPRAM_ARB_STATS_EN
  localparam logic [15:0] STEP = 16'd1;
`else
  localparam logic [15:0] STEP = 16'd0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid_a, in_ready_a, in_we_a;
  logic [AW-1:0] in_addr_a;
  logic [DW-1:0] in_data_a;
  logic          in_valid_b, in_ready_b, in_we_b;
  logic [AW-1:0] in_addr_b;
  logic [DW-1:0] in_data_b;
  logic          valid_a, ready_a, we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] data_a;
  logic          valid_b, ready_b, we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] data_b;
  logic [15:0]   conflict_cnt;

  logic [DW-1:0] mem [0:63];
  int n_checks;
  int n_fail;

  dpram_req_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_a(in_valid_a), .in_ready_a(in_ready_a), .in_we_a(in_we_a),
    .in_addr_a(in_addr_a), .in_data_a(in_data_a),
    .in_valid_b(in_valid_b), .in_ready_b(in_ready_b), .in_we_b(in_we_b),
    .in_addr_b(in_addr_b), .in_data_b(in_data_b),
    .valid_a(valid_a), .ready_a(ready_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a),
    .valid_b(valid_b), .ready_b(ready_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: commit writes on handshake
  always @(posedge clk) begin
    if (valid_a && ready_a && we_a) mem[addr_a] <= data_a;
    if (valid_b && ready_b && we_b) mem[addr_b] <= data_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid_a = 1'b1; in_we_a = 1'b1; in_addr_a = 6'h01; in_data_a = 8'h01;
    in_valid_b = 1'b1; in_we_b = 1'b1; in_addr_b = 6'h01; in_data_b = 8'h02;
    ready_a = 1'b1; ready_b = 1'b1;
    tick(); tick();
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a got=%b exp=0", valid_a); end
    n_checks++; if (valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b got=%b exp=0", valid_b); end
    n_checks++; if ({in_ready_a, in_ready_b} !== 2'b11) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=11", {in_ready_a, in_ready_b}); end
    n_checks++; if (conflict_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt got=%h exp=0000", conflict_cnt); end
    n_checks++; if ({we_a, addr_a, data_a} !== 15'h0) begin n_fail++; $display("FAIL reset_port_a got=%h exp=0", {we_a, addr_a, data_a}); end
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_independent();
    in_valid_a = 1'b1; in_we_a = 1'b1; in_addr_a = 6'h05; in_data_a = 8'hAA;
    in_valid_b = 1'b1; in_we_b = 1'b0; in_addr_b = 6'h09; in_data_b = 8'h00;
    tick();
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    n_checks++; if ({valid_a, valid_b} !== 2'b11) begin n_fail++; $display("FAIL indep_both_valid got=%b exp=11", {valid_a, valid_b}); end
    n_checks++; if ({we_a, addr_a, data_a} !== {1'b1, 6'h05, 8'hAA}) begin n_fail++; $display("FAIL indep_a_fields got=%h exp=%h", {we_a, addr_a, data_a}, {1'b1, 6'h05, 8'hAA}); end
    n_checks++; if ({we_b, addr_b} !== {1'b0, 6'h09}) begin n_fail++; $display("FAIL indep_b_fields got=%h exp=%h", {we_b, addr_b}, {1'b0, 6'h09}); end
    tick();
    n_checks++; if ({valid_a, valid_b} !== 2'b00) begin n_fail++; $display("FAIL indep_drained got=%b exp=00", {valid_a, valid_b}); end
    n_checks++; if (mem[5] !== 8'hAA) begin n_fail++; $display("FAIL indep_mem05 got=%h exp=AA", mem[5]); end
    n_checks++; if (conflict_cnt !== 16'h0000) begin n_fail++; $display("FAIL indep_cnt got=%h exp=0000", conflict_cnt); end
  endtask

  task automatic test_collision();
    in_valid_a = 1'b1; in_we_a = 1'b1; in_addr_a = 6'h10; in_data_a = 8'h11;
    in_valid_b = 1'b1; in_we_b = 1'b1; in_addr_b = 6'h10; in_data_b = 8'h22;
    tick();
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    n_checks++; if ({valid_a, valid_b} !== 2'b10) begin n_fail++; $display("FAIL coll_c1_valids got=%b exp=10", {valid_a, valid_b}); end
    n_checks++; if (in_ready_b !== 1'b0) begin n_fail++; $display("FAIL coll_c1_in_ready_b got=%b exp=0", in_ready_b); end
    tick();
    n_checks++; if ({valid_a, valid_b} !== 2'b01) begin n_fail++; $display("FAIL coll_c2_valids got=%b exp=01", {valid_a, valid_b}); end
    n_checks++; if (data_b !== 8'h22) begin n_fail++; $display("FAIL coll_c2_data_b got=%h exp=22", data_b); end
    tick();
    n_checks++; if (mem[16] !== 8'h22) begin n_fail++; $display("FAIL coll_mem10 got=%h exp=22", mem[16]); end
    n_checks++; if (conflict_cnt !== STEP) begin n_fail++; $display("FAIL coll_cnt got=%h exp=%h", conflict_cnt, STEP); end
  endtask

  task automatic test_fairness();
    in_valid_a = 1'b1; in_we_a = 1'b1; in_addr_a = 6'h10; in_data_a = 8'h11;
    in_valid_b = 1'b1; in_we_b = 1'b1; in_addr_b = 6'h10; in_data_b = 8'h22;
    tick();
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    n_checks++; if ({valid_a, valid_b} !== 2'b01) begin n_fail++; $display("FAIL fair_c1_valids got=%b exp=01", {valid_a, valid_b}); end
    tick();
    n_checks++; if ({valid_a, valid_b} !== 2'b10) begin n_fail++; $display("FAIL fair_c2_valids got=%b exp=10", {valid_a, valid_b}); end
    tick();
    n_checks++; if (mem[16] !== 8'h11) begin n_fail++; $display("FAIL fair_mem10 got=%h exp=11", mem[16]); end
    n_checks++; if (conflict_cnt !== 2 * STEP) begin n_fail++; $display("FAIL fair_cnt got=%h exp=%h", conflict_cnt, 2 * STEP); end
  endtask

  task automatic test_read_read();
    in_valid_a = 1'b1; in_we_a = 1'b0; in_addr_a = 6'h3F;
    in_valid_b = 1'b1; in_we_b = 1'b0; in_addr_b = 6'h3F;
    tick();
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    n_checks++; if ({valid_a, valid_b} !== 2'b11) begin n_fail++; $display("FAIL rr_valids got=%b exp=11", {valid_a, valid_b}); end
    tick();
    n_checks++; if ({valid_a, valid_b} !== 2'b00) begin n_fail++; $display("FAIL rr_drained got=%b exp=00", {valid_a, valid_b}); end
    n_checks++; if (conflict_cnt !== 2 * STEP) begin n_fail++; $display("FAIL rr_cnt got=%h exp=%h", conflict_cnt, 2 * STEP); end
  endtask

  task automatic test_backpressure();
    ready_a = 1'b0;
    in_valid_a = 1'b1; in_we_a = 1'b1; in_addr_a = 6'h20; in_data_a = 8'h33;
    in_valid_b = 1'b1; in_we_b = 1'b1; in_addr_b = 6'h20; in_data_b = 8'h44;
    tick();
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({valid_a, valid_b} !== 2'b10) begin n_fail++; $display("FAIL bp_stall%0d_valids got=%b exp=10", i, {valid_a, valid_b}); end
      n_checks++; if ({we_a, addr_a, data_a} !== {1'b1, 6'h20, 8'h33}) begin n_fail++; $display("FAIL bp_stall%0d_hold got=%h exp=%h", i, {we_a, addr_a, data_a}, {1'b1, 6'h20, 8'h33}); end
      if (i < 2) tick();
    end
    ready_a = 1'b1;
    tick();
    n_checks++; if ({valid_a, valid_b} !== 2'b01) begin n_fail++; $display("FAIL bp_b_turn got=%b exp=01", {valid_a, valid_b}); end
    n_checks++; if (mem[32] !== 8'h33) begin n_fail++; $display("FAIL bp_mem20_a got=%h exp=33", mem[32]); end
    tick();
    n_checks++; if (mem[32] !== 8'h44) begin n_fail++; $display("FAIL bp_mem20_b got=%h exp=44", mem[32]); end
    n_checks++; if (conflict_cnt !== 3 * STEP) begin n_fail++; $display("FAIL bp_cnt got=%h exp=%h", conflict_cnt, 3 * STEP); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 4; i++) begin
      a = 6'h30 + 6'(i);
      d = 8'h50 + 8'(i);
      in_valid_a = 1'b1; in_we_a = 1'b1; in_addr_a = a; in_data_a = d;
      n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready%0d got=%b exp=1", i, in_ready_a); end
      tick();
      n_checks++; if ({valid_a, addr_a, data_a} !== {1'b1, a, d}) begin n_fail++; $display("FAIL b2b_out%0d got=%h exp=%h", i, {valid_a, addr_a, data_a}, {1'b1, a, d}); end
    end
    in_valid_a = 1'b0;
    tick();
    n_checks++; if (mem[51] !== 8'h53) begin n_fail++; $display("FAIL b2b_mem33 got=%h exp=53", mem[51]); end
  endtask

  task automatic test_reset_midflight();
    ready_a = 1'b0;
    in_valid_a = 1'b1; in_we_a = 1'b1; in_addr_a = 6'h2A; in_data_a = 8'h77;
    tick();
    in_valid_a = 1'b0;
    n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL mid_loaded got=%b exp=1", valid_a); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({valid_a, addr_a, data_a} !== 15'h0) begin n_fail++; $display("FAIL mid_dropped got=%h exp=0", {valid_a, addr_a, data_a}); end
    n_checks++; if (conflict_cnt !== 16'h0000) begin n_fail++; $display("FAIL mid_cnt got=%h exp=0000", conflict_cnt); end
    tick();
    rst_n = 1'b1;
    ready_a = 1'b1;
    tick(); tick();
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL mid_no_replay got=%b exp=0", valid_a); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    test_reset();
    test_independent();
    test_collision();
    test_fairness();
    test_read_read();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
